// File: rtl/cla_pkg.sv
// cla_pkg: shared types and elaboration helpers for the pipelined CLA adder.
//   gp_t        - per-group {generate, propagate} pair
//   ng()        - number of lookahead groups for a WIDTH/GROUP pair
//   group_legal - lookahead group-size check used at elaboration
package cla_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Bit n set means GROUP=n is supported (2, 4, 8).
    localparam logic [31:0] LEGAL_GROUP_MASK = 32'h0000_0114;

    function automatic int ng(input int width, input int group);
        return width / group;
    endfunction

    function automatic bit group_legal(input int group);
        if (group < 0 || group > 31) return 1'b0;
        return LEGAL_GROUP_MASK[group];
    endfunction

endpackage

// File: rtl/cla_group.sv
// cla_group: combinational lookahead group of GROUP bits.
//   p, g  - per-bit propagate/generate slice
//   ci    - group carry-in
//   gg/gp - group generate/propagate (independent of ci)
//   s     - local sum bits p ^ carries
//   cmsb  - carry into the group's top bit (for signed overflow)
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] p,
    input  logic [GROUP-1:0] g,
    input  logic             ci,
    output logic             gg,
    output logic             gp,
    output logic [GROUP-1:0] s,
    output logic             cmsb
);

    logic [GROUP-1:0] c;
    logic             acc;
    logic             term;

    // Every carry is a flat sum of products over the group's p/g, no ripple.
    always_comb begin
        c    = '0;
        acc  = 1'b0;
        term = 1'b0;
        c[0] = ci;
        for (int i = 0; i < GROUP - 1; i++) begin
            acc = ci;
            for (int j = 0; j <= i; j++) acc = acc & p[j];
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term = term & p[m];
                acc = acc | term;
            end
            c[i+1] = acc;
        end
        gg = 1'b0;
        for (int j = 0; j < GROUP; j++) begin
            term = g[j];
            for (int m = j + 1; m < GROUP; m++) term = term & p[m];
            gg = gg | term;
        end
    end

    assign gp   = &p;
    assign s    = p ^ c;
    assign cmsb = c[GROUP-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: two-stage pipelined carry-lookahead adder/subtractor
// with valid/ready flow control.
//   A, B, CI, SUB, in_valid / in_ready  - operand beat (SUB=1: A-B, CI ignored)
//   S, CO, OVF, GG, GP, out_valid / out_ready - registered result
// Stage 1 registers per-group G/P plus raw p/g and c0; stage 2 resolves
// group carries and registers the result.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic             SUB,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OVF,
    output logic             GG,
    output logic             GP,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NG        = ng(WIDTH, GROUP);
    localparam bit PARAMS_OK = group_legal(GROUP) && (WIDTH % GROUP == 0) && (WIDTH >= GROUP);

    if (!PARAMS_OK) begin : g_param_check
        $error("cla_pipe_adder: WIDTH must be a multiple of GROUP and GROUP one of 2/4/8");
    end

    // ---------------- handshake ----------------
    logic s1_v, s2_v;
    logic s1_adv, s2_adv;

    assign s2_adv    = !s2_v || out_ready;
    assign s1_adv    = !s1_v || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_v;

    // ---------------- stage 1 ----------------
    logic [WIDTH-1:0] b_eff, p_in, g_in;
    gp_t  [NG-1:0]    gp_in;
    // Stage-1 groups only supply G/P; their sum outputs are deliberately dropped.
    logic [WIDTH-1:0] s1_sum_unused;
    logic [NG-1:0]    s1_cmsb_unused;

    assign b_eff = SUB ? ~B : B;
    assign p_in  = A ^ b_eff;
    assign g_in  = A & b_eff;

    for (genvar k = 0; k < NG; k++) begin : g_s1
        cla_group #(.GROUP(GROUP)) u_grp (
            .p    (p_in[k*GROUP +: GROUP]),
            .g    (g_in[k*GROUP +: GROUP]),
            .ci   (1'b0),
            .gg   (gp_in[k].g),
            .gp   (gp_in[k].p),
            .s    (s1_sum_unused[k*GROUP +: GROUP]),
            .cmsb (s1_cmsb_unused[k])
        );
    end

    logic [WIDTH-1:0] s1_p, s1_g;
    gp_t  [NG-1:0]    s1_gp;
    logic             s1_c0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v  <= 1'b0;
            s1_p  <= '0;
            s1_g  <= '0;
            s1_gp <= '0;
            s1_c0 <= 1'b0;
        end else if (s1_adv) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_p  <= p_in;
                s1_g  <= g_in;
                s1_gp <= gp_in;
                s1_c0 <= SUB | CI;
            end
        end
    end

    // ---------------- stage 2 ----------------
    logic [NG:0]   gc;
    logic [NG-1:0] grp_g, grp_p;
    logic          word_gg;
    logic          acc, term;

    // Inter-group lookahead in flat sum-of-products form.
    always_comb begin
        grp_g   = '0;
        grp_p   = '0;
        gc      = '0;
        acc     = 1'b0;
        term    = 1'b0;
        word_gg = 1'b0;
        for (int k = 0; k < NG; k++) begin
            grp_g[k] = s1_gp[k].g;
            grp_p[k] = s1_gp[k].p;
        end
        gc[0] = s1_c0;
        for (int k = 0; k < NG; k++) begin
            acc = s1_c0;
            for (int j = 0; j <= k; j++) acc = acc & grp_p[j];
            for (int j = 0; j <= k; j++) begin
                term = grp_g[j];
                for (int m = j + 1; m <= k; m++) term = term & grp_p[m];
                acc = acc | term;
            end
            gc[k+1] = acc;
        end
        // Word generate is the top carry with c0 forced to zero.
        for (int j = 0; j < NG; j++) begin
            term = grp_g[j];
            for (int m = j + 1; m < NG; m++) term = term & grp_p[m];
            word_gg = word_gg | term;
        end
    end

    logic [WIDTH-1:0] sum_nxt;
    logic [NG-1:0]    s2_gg_unused, s2_gp_unused;
    // Only the top group's MSB carry-in feeds OVF.
    logic [NG-1:0]    cmsb_top_unused;

    for (genvar k = 0; k < NG; k++) begin : g_s2
        cla_group #(.GROUP(GROUP)) u_grp (
            .p    (s1_p[k*GROUP +: GROUP]),
            .g    (s1_g[k*GROUP +: GROUP]),
            .ci   (gc[k]),
            .gg   (s2_gg_unused[k]),
            .gp   (s2_gp_unused[k]),
            .s    (sum_nxt[k*GROUP +: GROUP]),
            .cmsb (cmsb_top_unused[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v <= 1'b0;
            S    <= '0;
            CO   <= 1'b0;
            OVF  <= 1'b0;
            GG   <= 1'b0;
            GP   <= 1'b0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                S   <= sum_nxt;
                CO  <= gc[NG];
                OVF <= cmsb_top_unused[NG-1] ^ gc[NG];
                GG  <= word_gg;
                GP  <= &grp_p;
            end
        end
    end

endmodule
